// File: rtl/pos_truth_table_sweeper_if.sv
// rtl/pos_truth_table_sweeper_if.sv - stimulus/result bundle between sweeper and its controller
//
// Purpose: groups the sweep request, the function-block drive/return lines
// and the sweep results so they travel as one port.
// Signals:
//   start       request a sweep (controller -> sweeper)
//   f_in        F output of the function block under test (-> sweeper)
//   a, b, c, d  vector bits 3..0 driven onto the function block inputs
//   busy, done  sweep in progress / one-cycle completion pulse
//   table_out   captured truth table, bit i = F at minterm i
//   pass        table_out matched the expected mask
//   err_count   number of mismatching minterms (0..16)
//   first_fail  lowest mismatching minterm, 0 when none
// Modports: master = controller/bench side, slave = sweeper side.

interface pos_truth_table_sweeper_if;
  logic        start;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;

  modport master (
    output start, f_in,
    input  a, b, c, d, busy, done, table_out, pass, err_count, first_fail
  );

  modport slave (
    input  start, f_in,
    output a, b, c, d, busy, done, table_out, pass, err_count, first_fail
  );
endinterface

// File: rtl/pos_truth_table_sweeper.sv
// rtl/pos_truth_table_sweeper.sv - 4-input truth-table sweep and check against an expected mask
//
// Purpose: walks minterms 0..15 onto A,B,C,D, holds each for SETTLE_CYCLES,
// samples F on the following capture cycle, builds the truth table and
// compares it with EXPECTED (mismatch count, first failing minterm, pass).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of pos_truth_table_sweeper_if (see interface for fields)
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before capture (1..15)
//   EXPECTED       expected truth table, bit i = F at minterm {A,B,C,D} = i

module pos_truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hAAF8
) (
  input logic                           clk,
  input logic                           rst,
  pos_truth_table_sweeper_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  vector, vector_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] table_q, table_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        pass_q, pass_nxt;
  logic [4:0]  err_q, err_nxt;
  logic [3:0]  ff_q, ff_nxt;
  logic        mismatch;

  // State and every registered output; reset aborts a sweep with no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vector  <= 4'd0;
      cnt     <= 4'd0;
      table_q <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      ff_q    <= 4'd0;
    end else begin
      state   <= state_nxt;
      vector  <= vector_nxt;
      cnt     <= cnt_nxt;
      table_q <= table_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      pass_q  <= pass_nxt;
      err_q   <= err_nxt;
      ff_q    <= ff_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (vector == 4'd15) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // f_in only matters at the closing edge of CAPTURE.
  assign mismatch = (bus.f_in != EXPECTED[vector]);

  // Next values of the registered outputs; results hold unless a sweep is running.
  always_comb begin
    vector_nxt = vector;
    cnt_nxt    = cnt;
    table_nxt  = table_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    pass_nxt   = pass_q;
    err_nxt    = err_q;
    ff_nxt     = ff_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          vector_nxt = 4'd0;
          cnt_nxt    = 4'd0;
          table_nxt  = 16'd0;
          busy_nxt   = 1'b1;
          pass_nxt   = 1'b0;
          err_nxt    = 5'd0;
          ff_nxt     = 4'd0;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + 4'd1;
      end
      CAPTURE: begin
        table_nxt[vector] = bus.f_in;
        if (mismatch) begin
          err_nxt = err_q + 5'd1;
          // err_q still zero means this is the first miss of the sweep
          if (err_q == 5'd0) ff_nxt = vector;
        end
        if (vector == 4'd15) begin
          // pass is registered together with done so both are valid in DONE
          done_nxt = 1'b1;
          pass_nxt = (err_nxt == 5'd0);
        end else begin
          vector_nxt = vector + 4'd1;
          cnt_nxt    = 4'd0;
        end
      end
      DONE: begin
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.a          = vector[3];
  assign bus.b          = vector[2];
  assign bus.c          = vector[1];
  assign bus.d          = vector[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.table_out  = table_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_pos_truth_table_sweeper.sv
// tb/tb_pos_truth_table_sweeper.sv - self-checking bench for pos_truth_table_sweeper

module tb_pos_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pos_truth_table_sweeper_if bus0 ();
  pos_truth_table_sweeper_if bus1 ();

  pos_truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'hAAF8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pos_truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hAAF8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Function block behaviour: 0 = intended POS function, 1 = stuck at 0,
  // 2 = intended function with minterm 12 flipped to 1.
  int fmode [2] = '{0, 0};

  function automatic logic f_model(int mode, int m);
    logic is_zero;
    is_zero = (m == 0) || (m == 1) || (m == 2) || (m == 8) ||
              (m == 10) || (m == 12) || (m == 14);
    case (mode)
      1:       return 1'b0;
      2:       return (m == 12) ? 1'b1 : !is_zero;
      default: return !is_zero;
    endcase
  endfunction

  assign bus0.f_in = f_model(fmode[0], int'({bus0.a, bus0.b, bus0.c, bus0.d}));
  assign bus1.f_in = f_model(fmode[1], int'({bus1.a, bus1.b, bus1.c, bus1.d}));

  // Observed outputs packed as {vec[31:28], busy, done, pass, err[24:20], ff[19:16], table[15:0]}
  logic [31:0] obs [2];
  assign obs[0] = {bus0.a, bus0.b, bus0.c, bus0.d, bus0.busy, bus0.done, bus0.pass,
                   bus0.err_count, bus0.first_fail, bus0.table_out};
  assign obs[1] = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.busy, bus1.done, bus1.pass,
                   bus1.err_count, bus1.first_fail, bus1.table_out};

  function automatic int s_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic get_start(int i);
    return (i == 0) ? bus0.start : bus1.start;
  endfunction

  task automatic set_start(int i, logic v);
    if (i == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  // Timing model: p = clock edges since the accepting edge of the current sweep.
  bit act  [2] = '{1'b0, 1'b0};
  int p    [2] = '{0, 0};
  int fm_l [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        p[i]   <= 0;
      end else if ((!act[i] || p[i] >= 16 * (s_of(i) + 1) + 1) && get_start(i)) begin
        act[i]  <= 1'b1;
        p[i]    <= 0;
        fm_l[i] <= fmode[i];
      end else if (act[i] && p[i] < 100000) begin
        p[i] <= p[i] + 1;
      end
    end
  end

  function automatic logic [31:0] model_out(int i);
    int          s1;
    int          cap;
    int          err;
    int          ff;
    logic [3:0]  vec;
    logic        bsy;
    logic        dn;
    logic        ps;
    logic [15:0] tab;
    s1 = s_of(i) + 1;
    cap = 0; vec = 4'd0; bsy = 1'b0; dn = 1'b0;
    if (act[i]) begin
      if (p[i] < 16 * s1) begin
        cap = p[i] / s1;
        vec = 4'(p[i] / s1);
        bsy = 1'b1;
      end else begin
        cap = 16;
        vec = 4'd15;
        bsy = (p[i] == 16 * s1);
        dn  = bsy;
      end
    end
    tab = 16'd0; err = 0; ff = 0;
    for (int j = 0; j < cap; j++) begin
      tab[j] = f_model(fm_l[i], j);
      if (tab[j] != f_model(0, j)) begin
        if (err == 0) ff = j;
        err++;
      end
    end
    ps = act[i] && (cap == 16) && (err == 0);
    return {vec, bsy, dn, ps, 5'(err), 4'(ff), tab};
  endfunction

  task automatic chk(string name, int i, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, i, got, want, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] m;
      m = model_out(i);
      chk("vector",     i, 32'(obs[i][31:28]), 32'(m[31:28]));
      chk("busy",       i, 32'(obs[i][27]),    32'(m[27]));
      chk("done",       i, 32'(obs[i][26]),    32'(m[26]));
      chk("pass",       i, 32'(obs[i][25]),    32'(m[25]));
      chk("err_count",  i, 32'(obs[i][24:20]), 32'(m[24:20]));
      chk("first_fail", i, 32'(obs[i][19:16]), 32'(m[19:16]));
      chk("table_out",  i, 32'(obs[i][15:0]),  32'(m[15:0]));
    end
  end

  // Starts a sweep, releases start one cycle later unless hold is set, and
  // returns the number of negedges from the start request until done is seen.
  task automatic run(int i, bit hold, output int n);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    set_start(i, 1'b1);
    n = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (!hold && n == 1) set_start(i, 1'b0);
      if (obs[i][26]) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic chk_results(string tag, int i, logic [15:0] tab, int err, int ff, logic ps);
    chk({tag, "_table"}, i, 32'(obs[i][15:0]),  32'(tab));
    chk({tag, "_err"},   i, 32'(obs[i][24:20]), 32'(err));
    chk({tag, "_ff"},    i, 32'(obs[i][19:16]), 32'(ff));
    chk({tag, "_pass"},  i, 32'(obs[i][25]),    32'(ps));
  endtask

  initial begin
    int n;
    int dones;
    int done_n;
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    #1;
    chk("rst_state", 0, obs[0], 32'h0);
    chk("rst_state", 1, obs[1], 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // correct function block
    fmode[0] = 0;
    run(0, 1'b0, n);
    chk("latency_s2", 0, 32'(n), 32'd49);
    chk("done_busy", 0, 32'(obs[0][27]), 32'd1);
    chk_results("good", 0, 16'hAAF8, 0, 0, 1'b1);
    @(negedge clk);
    chk("busy_after", 0, 32'(obs[0][27]), 32'd0);
    chk("done_after", 0, 32'(obs[0][26]), 32'd0);
    chk("vec_after", 0, 32'(obs[0][31:28]), 32'd15);

    // stuck-at-0 block
    fmode[0] = 1;
    run(0, 1'b0, n);
    chk_results("zero", 0, 16'h0000, 9, 3, 1'b0);

    // minterm 12 flipped
    fmode[0] = 2;
    run(0, 1'b0, n);
    chk_results("flip12", 0, 16'hBAF8, 1, 12, 1'b0);

    // start pulses during vector 0, vector 7 and DONE are ignored
    fmode[0] = 0;
    @(negedge clk);
    bus0.start = 1'b1;
    n = 0; dones = 0; done_n = -10;
    for (int t = 0; t < 70; t++) begin
      @(negedge clk);
      n++;
      if (n == 1 || n == 3 || n == 24 || n == done_n + 1) bus0.start = 1'b0;
      if (n == 2) bus0.start = 1'b1;
      if (n == 23) begin
        chk("vec7_seen", 0, 32'(obs[0][31:28]), 32'd7);
        bus0.start = 1'b1;
      end
      if (obs[0][26]) begin
        dones++;
        done_n = n;
        bus0.start = 1'b1;
      end
    end
    chk("one_done", 0, 32'(dones), 32'd1);
    chk("retrig_latency", 0, 32'(done_n), 32'd49);
    chk("retrig_idle", 0, 32'(obs[0][27]), 32'd0);
    chk_results("retrig", 0, 16'hAAF8, 0, 0, 1'b1);

    // asynchronous reset mid-sweep at vector 7
    @(negedge clk);
    bus0.start = 1'b1;
    for (int t = 0; t < 23; t++) begin
      @(negedge clk);
      if (t == 0) bus0.start = 1'b0;
    end
    chk("pre_rst_vec", 0, 32'(obs[0][31:28]), 32'd7);
    chk("pre_rst_tab", 0, 32'(obs[0][15:0]), 32'h0078);
    #2 rst = 1'b1;
    #1;
    chk("rst_vec",  0, 32'(obs[0][31:28]), 32'd0);
    chk("rst_busy", 0, 32'(obs[0][27]),    32'd0);
    chk("rst_tab",  0, 32'(obs[0][15:0]),  32'd0);
    chk("rst_err",  0, 32'(obs[0][24:20]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 0, 32'(obs[0][27:25]), 32'd0);
    run(0, 1'b0, n);
    chk("post_rst_latency", 0, 32'(n), 32'd49);
    chk_results("post_rst", 0, 16'hAAF8, 0, 0, 1'b1);

    // SETTLE_CYCLES=1 with start held high: back-to-back sweeps
    fmode[1] = 0;
    run(1, 1'b1, n);
    chk("latency_s1", 1, 32'(n), 32'd33);
    chk_results("s1_first", 1, 16'hAAF8, 0, 0, 1'b1);
    @(negedge clk);
    chk("s1_idle_gap", 1, 32'(obs[1][27]), 32'd0);
    @(negedge clk);
    chk("s1_restart_busy", 1, 32'(obs[1][27]), 32'd1);
    chk_results("s1_cleared", 1, 16'h0000, 0, 0, 1'b0);
    bus1.start = 1'b0;
    @(negedge clk);
    chk("s1_hold_vec0", 1, 32'(obs[1][31:28]), 32'd0);
    @(negedge clk);
    chk("s1_vec1", 1, 32'(obs[1][31:28]), 32'd1);
    n = 3;
    while (n < 100 && !obs[1][26]) begin
      @(negedge clk);
      n++;
    end
    chk("s1_second_latency", 1, 32'(n), 32'd33);
    chk_results("s1_second", 1, 16'hAAF8, 0, 0, 1'b1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
